// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM capture path.
package pwm_pkg;

   localparam int unsigned PWM_SLOTS  = 256;
   localparam int unsigned PWM_DUTY_W = 8;

   typedef enum logic [1:0] {
      StAlign,
      StMeasure,
      StReport
   } pwm_state_e;

   // High count can reach PWM_SLOTS only on a noisy all-high window; clamp to full scale.
   function automatic logic [PWM_DUTY_W-1:0] sat_duty(input logic [PWM_DUTY_W:0] h);
      return h[PWM_DUTY_W] ? '1 : h[PWM_DUTY_W-1:0];
   endfunction

endpackage

// File: rtl/pwm_capture_if.sv
// Result channel of the PWM capture block: duty value with valid/ready and status flags.
interface pwm_capture_if
   import pwm_pkg::*;
();

   logic [PWM_DUTY_W-1:0] DUTY;
   logic                  DUTY_VALID;
   logic                  DUTY_READY;
   logic                  STUCK;
   logic                  OVERRUN;

   modport master (
      output DUTY,
      output DUTY_VALID,
      input  DUTY_READY,
      output STUCK,
      output OVERRUN
   );

   modport slave (
      input  DUTY,
      input  DUTY_VALID,
      output DUTY_READY,
      input  STUCK,
      input  OVERRUN
   );

endinterface

// File: rtl/pwm_in_sync.sv
// Synchronises the PWM line, samples it once per slot tick and flags a low-to-high step.
module pwm_in_sync (
   input  logic CLK,
   input  logic RST_N,
   input  logic pwm_in,
   input  logic tick,
   output logic smp,
   output logic rise
);

   logic [1:0] sync_q;
   logic       smp_q;
   logic       smp_prev_q;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sync_q     <= 2'b00;
         smp_q      <= 1'b0;
         smp_prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], pwm_in};
         if (tick) begin
            smp_q      <= sync_q[1];
            smp_prev_q <= smp_q;
         end
      end
   end

   assign smp  = smp_q;
   assign rise = smp_q & ~smp_prev_q;

endmodule

// File: rtl/pwm_capture.sv
// Recovers the 8-bit duty of an incoming PWM line by counting high slots over one
// rise-aligned 256-slot window; a line with no rise in 256 slots is reported as stuck.
module pwm_capture
   import pwm_pkg::*;
#(
   parameter int unsigned DIV_W = 12
) (
   input  logic          CLK,
   input  logic          RST_N,
   input  logic          PWM_IN,
   pwm_capture_if.master res
);

   localparam logic [PWM_DUTY_W-1:0] SlotLast = PWM_DUTY_W'(PWM_SLOTS - 1);

   logic [DIV_W-1:0]      div_q;
   logic                  tick;
   logic                  smp;
   logic                  rise;
   pwm_state_e            state_q;
   logic [PWM_DUTY_W-1:0] slot_q;
   logic [PWM_DUTY_W:0]   hcnt_q;
   logic [PWM_DUTY_W:0]   hcnt_nxt;
   logic [PWM_DUTY_W-1:0] res_duty_q;
   logic                  res_stuck_q;

   pwm_in_sync u_sync (
      .CLK    (CLK),
      .RST_N  (RST_N),
      .pwm_in (PWM_IN),
      .tick   (tick),
      .smp    (smp),
      .rise   (rise)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         div_q <= '0;
      end else begin
         div_q <= div_q + DIV_W'(1);
      end
   end

   assign tick     = &div_q;
   assign hcnt_nxt = hcnt_q + {{PWM_DUTY_W{1'b0}}, smp};

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q        <= StAlign;
         slot_q         <= '0;
         hcnt_q         <= '0;
         res_duty_q     <= '0;
         res_stuck_q    <= 1'b0;
         res.DUTY       <= '0;
         res.DUTY_VALID <= 1'b0;
         res.STUCK      <= 1'b0;
         res.OVERRUN    <= 1'b0;
      end else begin
         if (res.DUTY_VALID && res.DUTY_READY) begin
            res.DUTY_VALID <= 1'b0;
         end
         case (state_q)
            StAlign: begin
               if (tick) begin
                  if (rise) begin
                     // The rising sample itself is slot 0 of the window.
                     hcnt_q  <= PWM_DUTY_W'(1) + '0;
                     slot_q  <= PWM_DUTY_W'(1);
                     state_q <= StMeasure;
                  end else begin
                     slot_q <= slot_q + PWM_DUTY_W'(1);
                     if (slot_q == SlotLast) begin
                        res_duty_q  <= smp ? '1 : '0;
                        res_stuck_q <= 1'b1;
                        state_q     <= StReport;
                     end
                  end
               end
            end
            StMeasure: begin
               if (tick) begin
                  hcnt_q <= hcnt_nxt;
                  slot_q <= slot_q + PWM_DUTY_W'(1);
                  if (slot_q == SlotLast) begin
                     res_duty_q  <= sat_duty(hcnt_nxt);
                     res_stuck_q <= 1'b0;
                     state_q     <= StReport;
                  end
               end
            end
            StReport: begin
               res.DUTY  <= res_duty_q;
               res.STUCK <= res_stuck_q;
               if (res.DUTY_VALID && !res.DUTY_READY) begin
                  res.OVERRUN <= 1'b1;
               end
               // A same-cycle acceptance is superseded by the fresh result.
               res.DUTY_VALID <= 1'b1;
               slot_q         <= '0;
               hcnt_q         <= '0;
               state_q        <= StAlign;
            end
            default: state_q <= StAlign;
         endcase
      end
   end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture driven by a cycle model of the PWM generator.
module tb_pwm_capture;

   localparam int unsigned DIV_W = 2;

   logic       CLK       = 1'b0;
   logic       RST_N     = 1'b0;
   logic       pwm_in;
   logic       force_en  = 1'b1;
   logic       force_val = 1'b0;
   logic [1:0] gdiv      = 2'd0;
   logic [7:0] gslot     = 8'd0;
   logic [8:0] gnum      = 9'd0;
   logic [8:0] gnum_req  = 9'd0;
   int         cyc       = 0;
   int         rel_cyc   = 0;
   int         checks    = 0;
   int         failures  = 0;

   pwm_capture_if res ();

   pwm_capture #(.DIV_W(DIV_W)) dut (
      .CLK    (CLK),
      .RST_N  (RST_N),
      .PWM_IN (pwm_in),
      .res    (res)
   );

   always #5 CLK = ~CLK;

   // Generator model: high for gnum of every 256 slots, duty latched at period start.
   always @(posedge CLK) begin
      cyc  <= cyc + 1;
      gdiv <= gdiv + 2'd1;
      if (gdiv == 2'd3) begin
         gslot <= gslot + 8'd1;
         if (gslot == 8'd255) gnum <= gnum_req;
      end
   end

   assign pwm_in = force_en ? force_val : ({1'b0, gslot} < gnum);

   task automatic wait_result(input int budget, output logic [7:0] d, output logic s,
                              output int stamp);
      int n = 0;
      while (n < budget) begin
         @(posedge CLK);
         #1;
         n++;
         if (res.DUTY_VALID) break;
      end
      checks++;
      if (res.DUTY_VALID !== 1'b1) begin
         failures++;
         $display("FAIL result_timeout got=no_valid_after_%0d want=valid", budget);
      end
      d     = res.DUTY;
      s     = res.STUCK;
      stamp = cyc;
   endtask

   task automatic test_reset();
      RST_N            = 1'b0;
      res.DUTY_READY   = 1'b0;
      force_en         = 1'b1;
      force_val        = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      checks++;
      if (res.DUTY !== 8'd0) begin
         failures++; $display("FAIL reset_duty got=%0d want=0", res.DUTY);
      end
      checks++;
      if (res.DUTY_VALID !== 1'b0) begin
         failures++; $display("FAIL reset_valid got=%b want=0", res.DUTY_VALID);
      end
      checks++;
      if (res.STUCK !== 1'b0) begin
         failures++; $display("FAIL reset_stuck got=%b want=0", res.STUCK);
      end
      checks++;
      if (res.OVERRUN !== 1'b0) begin
         failures++; $display("FAIL reset_overrun got=%b want=0", res.OVERRUN);
      end
      @(negedge CLK);
      RST_N   = 1'b1;
      rel_cyc = cyc;
   endtask

   task automatic test_const_low();
      logic [7:0] d;
      logic       s;
      int         t1, t2;
      wait_result(1200, d, s, t1);
      checks++;
      if (t1 - rel_cyc !== 1025) begin
         failures++; $display("FAIL low_latency got=%0d want=1025", t1 - rel_cyc);
      end
      checks++;
      if (d !== 8'd0 || s !== 1'b1) begin
         failures++; $display("FAIL low_first got=%0d/%b want=0/1", d, s);
      end
      res.DUTY_READY = 1'b1;
      @(posedge CLK);
      #1;
      res.DUTY_READY = 1'b0;
      checks++;
      if (res.DUTY_VALID !== 1'b0) begin
         failures++; $display("FAIL low_accept got=%b want=0", res.DUTY_VALID);
      end
      wait_result(1200, d, s, t2);
      checks++;
      if (t2 - t1 !== 1024) begin
         failures++; $display("FAIL low_period got=%0d want=1024", t2 - t1);
      end
      checks++;
      if (d !== 8'd0 || s !== 1'b1) begin
         failures++; $display("FAIL low_second got=%0d/%b want=0/1", d, s);
      end
      res.DUTY_READY = 1'b1;
   endtask

   task automatic test_duty(input logic [8:0] num, input int nchk);
      logic [7:0] d;
      logic       s;
      int         t;
      force_en       = 1'b0;
      gnum_req       = num;
      res.DUTY_READY = 1'b1;
      repeat (2) wait_result(3000, d, s, t);
      for (int i = 0; i < nchk; i++) begin
         wait_result(3000, d, s, t);
         checks++;
         if (d !== num[7:0] || s !== 1'b0) begin
            failures++;
            $display("FAIL duty_%0d got=%0d/%b want=%0d/0", num, d, s, num);
         end
      end
   endtask

   task automatic test_const_high();
      logic [7:0] d;
      logic       s;
      int         t;
      force_en       = 1'b1;
      force_val      = 1'b1;
      res.DUTY_READY = 1'b1;
      repeat (2) wait_result(3000, d, s, t);
      wait_result(3000, d, s, t);
      checks++;
      if (d !== 8'd255 || s !== 1'b1) begin
         failures++; $display("FAIL high_stuck got=%0d/%b want=255/1", d, s);
      end
      // One-slot low gap while aligning: next window is 256 highs.
      force_val = 1'b0;
      repeat (4) @(posedge CLK);
      #1;
      force_val = 1'b1;
      wait_result(3000, d, s, t);
      checks++;
      if (d !== 8'd255 || s !== 1'b0) begin
         failures++; $display("FAIL high_gap got=%0d/%b want=255/0", d, s);
      end
      wait_result(3000, d, s, t);
      checks++;
      if (d !== 8'd255 || s !== 1'b1) begin
         failures++; $display("FAIL high_after_gap got=%0d/%b want=255/1", d, s);
      end
   endtask

   task automatic test_overrun();
      logic [7:0] d;
      logic       s;
      int         t;
      int         n = 0;
      force_en       = 1'b0;
      gnum_req       = 9'd64;
      res.DUTY_READY = 1'b1;
      repeat (2) wait_result(3000, d, s, t);
      wait_result(3000, d, s, t);
      checks++;
      if (d !== 8'd64) begin
         failures++; $display("FAIL ovr_first got=%0d want=64", d);
      end
      @(posedge CLK);
      #1;
      res.DUTY_READY = 1'b0;
      checks++;
      if (res.OVERRUN !== 1'b0) begin
         failures++; $display("FAIL ovr_early got=%b want=0", res.OVERRUN);
      end
      gnum_req = 9'd200;
      wait_result(3000, d, s, t);
      repeat (6000) @(posedge CLK);
      #1;
      checks++;
      if (res.DUTY !== 8'd200 || res.STUCK !== 1'b0) begin
         failures++; $display("FAIL ovr_duty got=%0d/%b want=200/0", res.DUTY, res.STUCK);
      end
      checks++;
      if (res.OVERRUN !== 1'b1 || res.DUTY_VALID !== 1'b1) begin
         failures++;
         $display("FAIL ovr_flag got=%b/%b want=1/1", res.OVERRUN, res.DUTY_VALID);
      end
      // Accept mid-period, far from any result update.
      while (gslot != 8'd128 && n < 1100) begin
         @(posedge CLK);
         #1;
         n++;
      end
      res.DUTY_READY = 1'b1;
      @(posedge CLK);
      #1;
      res.DUTY_READY = 1'b0;
      checks++;
      if (res.DUTY_VALID !== 1'b0 || res.OVERRUN !== 1'b1) begin
         failures++;
         $display("FAIL ovr_accept got=%b/%b want=0/1", res.DUTY_VALID, res.OVERRUN);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] d;
      logic       s;
      int         t;
      force_en       = 1'b0;
      gnum_req       = 9'd128;
      res.DUTY_READY = 1'b1;
      repeat (2) wait_result(3000, d, s, t);
      repeat (400) @(posedge CLK);
      #2;
      RST_N = 1'b0;
      #1;
      checks++;
      if (res.DUTY !== 8'd0 || res.DUTY_VALID !== 1'b0 || res.STUCK !== 1'b0 ||
          res.OVERRUN !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset got=%0d/%b/%b/%b want=0/0/0/0", res.DUTY, res.DUTY_VALID,
                  res.STUCK, res.OVERRUN);
      end
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RST_N   = 1'b1;
      rel_cyc = cyc;
      wait_result(3000, d, s, t);
      checks++;
      if (t - rel_cyc < 1029) begin
         failures++; $display("FAIL mid_latency got=%0d want>=1029", t - rel_cyc);
      end
      checks++;
      if (d !== 8'd128 || s !== 1'b0) begin
         failures++; $display("FAIL mid_result got=%0d/%b want=128/0", d, s);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] d;
      logic       s;
      int         ta, tb, period;
      gnum_req       = 9'd100;
      res.DUTY_READY = 1'b1;
      repeat (2) wait_result(3000, d, s, ta);
      wait_result(3000, d, s, ta);
      wait_result(3000, d, s, tb);
      res.DUTY_READY = 1'b0;
      period = tb - ta;
      checks++;
      if (d !== 8'd100 || period !== 1024) begin
         failures++; $display("FAIL b2b_setup got=%0d/%0d want=100/1024", d, period);
      end
      repeat (period - 1) @(posedge CLK);
      #1;
      res.DUTY_READY = 1'b1;
      @(posedge CLK);
      #1;
      res.DUTY_READY = 1'b0;
      checks++;
      if (res.DUTY_VALID !== 1'b1 || res.OVERRUN !== 1'b0 || res.DUTY !== 8'd100) begin
         failures++;
         $display("FAIL b2b_report got=%b/%b/%0d want=1/0/100", res.DUTY_VALID, res.OVERRUN,
                  res.DUTY);
      end
      @(posedge CLK);
      #1;
      checks++;
      if (res.DUTY_VALID !== 1'b1) begin
         failures++; $display("FAIL b2b_hold got=%b want=1", res.DUTY_VALID);
      end
      res.DUTY_READY = 1'b1;
      @(posedge CLK);
      #1;
      res.DUTY_READY = 1'b0;
      checks++;
      if (res.DUTY_VALID !== 1'b0 || res.OVERRUN !== 1'b0) begin
         failures++;
         $display("FAIL b2b_drain got=%b/%b want=0/0", res.DUTY_VALID, res.OVERRUN);
      end
   endtask

   initial begin
      gdiv           = 2'($urandom_range(3, 0));
      gslot          = 8'($urandom_range(255, 0));
      res.DUTY_READY = 1'b0;
      test_reset();
      test_const_low();
      test_duty(9'd128, 2);
      test_duty(9'd1, 1);
      test_duty(9'd255, 1);
      test_const_high();
      test_overrun();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
